// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream from a serial receiver,
// writes the contained 16-bit words into instruction memory, and holds the
// processor in reset until a complete frame with a good checksum has landed.
//
// Handshake: a byte transfers on a rising clk edge where rx_valid and
// rx_ready are both 1. rx_ready depends on state (and rst) only, never on
// rx_valid, so the sender may raise rx_valid at any time and hold it until
// the transfer edge.
module prog_loader #(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int          CNT_W     = $clog2(TIMEOUT + 1);
  localparam int          CMP_W     = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [7:0]          nwords_q, nwords_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          csum_q, csum_d;
  logic [CNT_W-1:0]    idle_q, idle_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         data_q, data_d;

  logic accept;
  logic last_word;
  logic idle_expired;

  assign accept       = rx_valid && (state_q != S_WRITE);
  assign last_word    = (CMP_W'(idx_q) + CMP_W'(1)) == CMP_W'(nwords_q);
  assign idle_expired = (idle_q == CNT_W'(TIMEOUT - 1));

  // State register and datapath flops; reset forces IDLE asynchronously,
  // which also drops imem_we at once since it is decoded from state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      nwords_q <= '0;
      hi_q     <= '0;
      csum_q   <= '0;
      idle_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nwords_q <= nwords_d;
      hi_q     <= hi_d;
      csum_q   <= csum_d;
      idle_q   <= idle_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic: frame parsing, checksum accumulation, idle timeout.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nwords_d = nwords_q;
    hi_d     = hi_q;
    csum_d   = csum_q;
    idle_d   = idle_q;
    addr_d   = addr_q;
    data_d   = data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        idle_d = '0;
        if (accept && rx_data == SYNC_BYTE) begin
          state_d = S_COUNT;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      S_COUNT, S_HI, S_LO, S_CSUM: begin
        if (accept) begin
          idle_d = '0;
          case (state_q)
            S_COUNT: begin
              if (rx_data == 8'd0 || 32'(rx_data) > MAX_WORDS) begin
                state_d = S_ERROR;
              end else begin
                nwords_d = rx_data;
                state_d  = S_HI;
              end
            end
            S_HI: begin
              hi_d    = rx_data;
              csum_d  = csum_q ^ rx_data;
              state_d = S_LO;
            end
            S_LO: begin
              data_d  = {hi_q, rx_data};
              addr_d  = idx_q;
              csum_d  = csum_q ^ rx_data;
              state_d = S_WRITE;
            end
            default: begin
              state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
            end
          endcase
        end else if (idle_expired) begin
          state_d = S_ERROR;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        // The write cycle itself accepts nothing, so it counts as idle time.
        idle_d  = idle_q + CNT_W'(1);
        idx_d   = idx_q + ADDR_W'(1);
        state_d = last_word ? S_CSUM : S_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registered datapath only.
  always_comb begin
    rx_ready  = !rst && (state_q != S_WRITE);
    imem_we   = (state_q == S_WRITE);
    imem_addr = addr_q;
    imem_data = data_q;
    cpu_rst   = (state_q != S_DONE);
    busy      = (state_q == S_COUNT) || (state_q == S_HI) || (state_q == S_LO) ||
                (state_q == S_WRITE) || (state_q == S_CSUM);
    done      = (state_q == S_DONE);
    err       = (state_q == S_ERROR);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: fixed frame vectors, hand-written multi-cycle
// sequences (idle timeout, reset mid-load) and random frames scored against
// a frame-level parser model.
module tb_prog_loader;

  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 16;
  localparam int W       = ADDR_W + 16;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [7:0]   stim_q[$];
  int           obs_rd = 0;
  int           bad_rdy = 0;
  int           n_tests = 0;
  int           n_fail  = 0;

  // Write monitor: records every write-strobe cycle.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      obs_q.push_back({imem_addr, imem_data});
      if (rx_ready !== 1'b0) bad_rdy++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_data", 32'(imem_data), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns just after the edge that transferred the byte.
  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_stim(input int max_gap);
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i]);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // st: 0 never loaded, 1 done, 2 error, 3 load in progress
  task automatic check_status(input int st);
    check("done", 32'(done), 32'(st == 1));
    check("err", 32'(err), 32'(st == 2));
    check("cpu_rst", 32'(cpu_rst), 32'(st != 1));
    check("busy", 32'(busy), 32'(st == 3));
  endtask

  task automatic check_writes();
    check("write_count", 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      check("write_addr_data", 32'(obs_q[obs_rd]), 32'(exp_q.pop_front()));
      obs_rd++;
    end
    obs_rd = obs_q.size();
    exp_q.delete();
    check("rx_ready_in_write", 32'(bad_rdy), 32'd0);
  endtask

  // ---------------- reference model ----------------
  // Walks the byte stream frame by frame and lists the words that must be
  // written; returns the load status after the stream.
  task automatic model_stream(input int prev, output int st);
    int i;
    int n;
    logic [7:0]  x;
    logic [15:0] word;
    i  = 0;
    st = prev;
    while (i < stim_q.size()) begin
      if (stim_q[i] != 8'hA5) begin
        i++;
      end else begin
        i++;
        st = 3;
        if (i >= stim_q.size()) break;
        n = int'(stim_q[i]);
        i++;
        if (n == 0 || n > (1 << ADDR_W)) begin
          st = 2;
        end else begin
          x = 8'h00;
          for (int w = 0; w < n; w++) begin
            if (i + 1 >= stim_q.size()) begin
              i = stim_q.size();
              break;
            end
            word = {stim_q[i], stim_q[i+1]};
            i += 2;
            x ^= word[15:8] ^ word[7:0];
            exp_q.push_back({ADDR_W'(w), word});
          end
          if (i < stim_q.size()) begin
            st = (stim_q[i] == x) ? 1 : 2;
            i++;
          end
        end
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int           len;
    logic [95:0]  bytes;   // right-aligned, first byte most significant
    int           nwr;
    logic [W-1:0] wr0;
    logic [W-1:0] wr1;
    logic         exp_done;
    logic         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic load_vec(input vec_t v);
    stim_q.delete();
    for (int k = 0; k < v.len; k++) stim_q.push_back(v.bytes[(v.len - 1 - k) * 8 +: 8]);
    if (v.nwr > 0) exp_q.push_back(v.wr0);
    if (v.nwr > 1) exp_q.push_back(v.wr1);
  endtask

  task automatic count_to_err(input string name);
    int c;
    c = 0;
    while (!err && c < 40) begin
      @(posedge clk);
      #1 c++;
    end
    check(name, 32'(c), 32'(TIMEOUT));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st;
    int n;
    logic [7:0] x;
    logic [7:0] b;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;

    vecs[0] = '{7, 96'hA5021234ABCD40, 2, {7'd0, 16'h1234}, {7'd1, 16'hABCD}, 1'b1, 1'b0};
    vecs[1] = '{7, 96'hA5021234ABCD41, 2, {7'd0, 16'h1234}, {7'd1, 16'hABCD}, 1'b0, 1'b1};
    vecs[2] = '{8, 96'h00FF3CA501000707, 1, {7'd0, 16'h0007}, '0, 1'b1, 1'b0};
    vecs[3] = '{2, 96'hA500, 0, '0, '0, 1'b0, 1'b1};
    vecs[4] = '{2, 96'hA581, 0, '0, '0, 1'b0, 1'b1};
    vecs[5] = '{5, 96'hA50155AAFF, 1, {7'd0, 16'h55AA}, '0, 1'b1, 1'b0};
    vecs[6] = '{9, 96'hA500A581A50155AAFF, 1, {7'd0, 16'h55AA}, '0, 1'b1, 1'b0};
    vecs[7] = '{7, 96'hA502A5A5000101, 2, {7'd0, 16'hA5A5}, {7'd1, 16'h0001}, 1'b1, 1'b0};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      load_vec(vecs[v]);
      send_stim(0);
      settle();
      check("vec_done", 32'(done), 32'(vecs[v].exp_done));
      check("vec_err", 32'(err), 32'(vecs[v].exp_err));
      check("vec_cpu_rst", 32'(cpu_rst), 32'(!vecs[v].exp_done));
      check("vec_busy", 32'(busy), 32'd0);
      check_writes();
    end

    // Timeout while waiting for the low byte.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    count_to_err("timeout_lo_cycles");
    check_status(2);
    check_writes();

    // Timeout while waiting for the count byte.
    send_byte(8'hA5);
    check("count_busy", 32'(busy), 32'd1);
    count_to_err("timeout_count_cycles");
    check_status(2);

    // Timeout across a write cycle: the write counts as idle time.
    do_reset();
    exp_q.push_back({7'd0, 16'h1234});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    count_to_err("timeout_after_write_cycles");
    check_status(2);
    check_writes();

    // Reset in the write cycle aborts it immediately.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    check("mid_we", 32'(imem_we), 32'd1);
    check("mid_addr", 32'(imem_addr), 32'd0);
    check("mid_data", 32'(imem_data), 32'h1234);
    check("mid_rx_ready", 32'(rx_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort_we", 32'(imem_we), 32'd0);
    check("abort_rx_ready", 32'(rx_ready), 32'd0);
    check("abort_addr", 32'(imem_addr), 32'd0);
    check("abort_data", 32'(imem_data), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    settle();
    check_status(0);
    check_writes();
    load_vec(vecs[0]);
    send_stim(0);
    settle();
    check_status(1);
    check_writes();

    // Random frames, back to back without reset.
    st = 1;
    for (int t = 0; t < 40; t++) begin
      stim_q.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        stim_q.push_back((b == 8'hA5) ? 8'h00 : b);
      end
      stim_q.push_back(8'hA5);
      case ($urandom_range(0, 15))
        0:       n = 0;
        1:       n = 129;
        2:       n = 128;
        default: n = $urandom_range(1, 5);
      endcase
      stim_q.push_back(8'(n));
      if (n != 0 && n <= 128) begin
        x = 8'h00;
        for (int k = 0; k < 2 * n; k++) begin
          b = 8'($urandom_range(0, 255));
          x ^= b;
          stim_q.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
        stim_q.push_back(x);
      end
      model_stream(st, st);
      send_stim(3);
      settle();
      check_status(st);
      check_writes();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 7, instruction-memory word-address width (capacity 2**ADDR_W words).
REQ-002 Parameter TIMEOUT, default 50000, maximum idle clk cycles between accepted bytes during a load.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_data  input  8  byte from the serial receiver.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 imem_data  output  16  instruction word to write.
REQ-011 cpu_rst  output  1  processor reset, held high until a load succeeds.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  last load succeeded.
REQ-014 err  output  1  last load failed.

Function
REQ-015 A byte SHALL be accepted only on a rising clk edge with rx_valid=1 and rx_ready=1.
REQ-016 Frame format SHALL be: 0xA5, count N (words), 2N data bytes (high byte first per word), checksum byte = XOR of all 2N data bytes.
REQ-017 States SHALL be IDLE, COUNT, HI, LO, WRITE, CSUM, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR: accepted 0xA5 -> COUNT, clearing word index, checksum, done, err and asserting cpu_rst; any other byte discarded, state unchanged.
REQ-019 COUNT: accepted N with N=0 or N>2**ADDR_W -> ERROR; otherwise latch N -> HI.
REQ-020 HI: accepted byte latched as word[15:8], XORed into checksum -> LO.
REQ-021 LO: accepted byte forms word[7:0], XORed into checksum -> WRITE.
REQ-022 WRITE: exactly one cycle; imem_we=1, imem_addr=word index (0 for first word), imem_data=assembled word, rx_ready=0; index increments; -> CSUM if this was word N-1, else HI.
REQ-023 CSUM: accepted byte equal to running checksum -> DONE, else -> ERROR.
REQ-024 rx_ready SHALL be 1 in every state except WRITE and while rst is high.
REQ-025 imem_we SHALL be 0 outside WRITE; imem_addr/imem_data hold last value otherwise.
REQ-026 Idle counter SHALL clear on every accepted byte and on entry to COUNT; in COUNT/HI/LO/CSUM, when it reaches TIMEOUT cycles with no accepted byte, state -> ERROR on that edge; counter inactive in other states, WRITE counts as idle.
REQ-027 cpu_rst SHALL be 0 only in DONE; busy=1 in COUNT/HI/LO/WRITE/CSUM; done=1 only in DONE; err=1 only in ERROR.
REQ-028 Words already written before an ERROR SHALL remain written; no write occurs after ERROR.
REQ-029 All outputs SHALL be registered or decoded from state only; no combinational path from rx_data/rx_valid to any output.

Reset
REQ-030 While rst=1 (asynchronously): state IDLE, cpu_rst=1, rx_ready=0, imem_we=0, imem_addr=0, imem_data=0, busy=0, done=0, err=0, counters and checksum 0.
REQ-031 Reset mid-load SHALL abort immediately; imem_we drops in the same instant; no further writes until a new frame.

Verification
REQ-032 Bytes A5 02 12 34 AB CD 40 -> writes addr0=0x1234, addr1=0xABCD, each imem_we one cycle; then done=1, cpu_rst=0, busy=0.
REQ-033 Same frame, checksum 0x41 -> two writes occur, then err=1, done=0, cpu_rst=1.
REQ-034 Bytes 00 FF 3C before A5 01 00 07 07 -> leading bytes ignored, addr0=0x0007 written, done=1.
REQ-035 A5 00 -> err=1, no write; A5 81 (ADDR_W=7) -> err=1, no write; then A5 01 55 AA FF -> done=1, addr0=0x55AA.
REQ-036 TIMEOUT=16: A5 01 12 then rx_valid=0 -> err=1 exactly 16 cycles after 0x12 accepted, no write.
REQ-037 rst pulse after A5 02 12 34 -> IDLE, all outputs at reset values, cpu_rst=1; next full valid frame loads normally.
